// File: rtl/prog_counter_pkg.sv
// prog_counter_pkg: shared types for the programmable counter.
//   cnt_mode_e : counting mode encoding carried on the 2-bit mode port.
//   os_state_e : one-shot run state (IDLE / RUN / DONE).
package prog_counter_pkg;

  typedef enum logic [1:0] {
    CNT_WRAP    = 2'b00,
    CNT_SAT     = 2'b01,
    CNT_ONESHOT = 2'b10,
    CNT_RSVD    = 2'b11
  } cnt_mode_e;

  typedef enum logic [1:0] {
    OS_IDLE = 2'b00,
    OS_RUN  = 2'b01,
    OS_DONE = 2'b10
  } os_state_e;

endpackage

// File: rtl/prog_counter.sv
// prog_counter: up/down counter over 0..limit with wrap, saturate and
// one-shot modes, synchronous clear/load, and a registered terminal-count
// pulse.
//   clk, rst_n : clock, async active-low reset
//   clr, load  : synchronous clear to start value / load of load_val
//   load_val   : value to load (clamped to limit)
//   start      : arms a one-shot run (mode 10 only)
//   en, dir    : step enable, direction (0 up, 1 down)
//   mode       : 00 wrap, 01 saturate, 10 one-shot, 11 as wrap
//   limit      : run-time modulus, counts span 0..limit
//   count, tc  : current count, one-cycle terminal-count pulse
//   busy, done : one-shot FSM is RUN / DONE
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  os_state_e        r_state;

  cnt_mode_e        w_mode;
  logic [WIDTH-1:0] w_term;
  logic [WIDTH-1:0] w_start;
  logic             w_wrap;
  logic             w_at_term;
  logic             w_oor;
  logic             w_step_ok;
  logic [WIDTH-1:0] w_nxt_count;
  logic             w_nxt_tc;
  os_state_e        w_nxt_state;

  always_comb begin
    w_mode      = cnt_mode_e'(mode);
    w_term      = dir ? '0 : limit;
    w_start     = dir ? limit : '0;
    w_wrap      = (w_mode == CNT_WRAP) || (w_mode == CNT_RSVD);
    w_at_term   = (r_count == w_term);
    // limit may drop below the current count at run time
    w_oor       = (r_count > limit);
    // one-shot only steps while running; other modes step on every en
    w_step_ok   = en && ((w_mode != CNT_ONESHOT) || (r_state == OS_RUN));

    w_nxt_count = r_count;
    w_nxt_state = r_state;
    w_nxt_tc    = 1'b0;

    if (clr) begin
      w_nxt_count = w_start;
      w_nxt_state = OS_IDLE;
    end else if (load) begin
      w_nxt_count = (load_val > limit) ? limit : load_val;
    end else if ((w_mode == CNT_ONESHOT) && start) begin
      w_nxt_count = w_start;
      w_nxt_state = OS_RUN;
    end else if (w_step_ok) begin
      if (w_oor)
        w_nxt_count = w_term;
      else if (w_at_term)
        w_nxt_count = w_wrap ? w_start : r_count;
      else if (dir)
        w_nxt_count = r_count - WIDTH'(1);
      else
        w_nxt_count = r_count + WIDTH'(1);
      // sitting at T only re-pulses in wrap mode (covers limit=0 wrap)
      w_nxt_tc = (w_nxt_count == w_term) && (w_wrap || !w_at_term);
      if ((w_mode == CNT_ONESHOT) && (w_nxt_count == w_term))
        w_nxt_state = OS_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_state <= OS_IDLE;
    end else begin
      r_count <= w_nxt_count;
      r_tc    <= w_nxt_tc;
      r_state <= w_nxt_state;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign busy  = (r_state == OS_RUN);
  assign done  = (r_state == OS_DONE);

endmodule

// File: tb/tb_prog_counter.sv
module tb_prog_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0, load = 1'b0, start = 1'b0, en = 1'b0, dir = 1'b0;
  logic [W-1:0] load_val = '0, limit = '0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] count;
  logic         tc, busy, done;

  int errors = 0;
  int checks = 0;

  // reference model: count value, tc, and run state 0=idle 1=run 2=done
  int m_count = 0;
  bit m_tc = 0;
  int m_state = 0;

  prog_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .start(start), .en(en), .dir(dir), .mode(mode), .limit(limit),
    .count(count), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Advance one clock edge; the model computes the expected outcome from the
  // inputs present at the edge. Outputs are then settled 1 time unit later.
  task automatic tick();
    int t, s, c, nc, st;
    bit ntc, wrapm;
    t = dir ? 0 : int'(limit);
    s = dir ? int'(limit) : 0;
    c = m_count; nc = c; ntc = 0; st = m_state;
    wrapm = (mode == 2'd0) || (mode == 2'd3);
    if (clr) begin
      nc = s; st = 0;
    end else if (load) begin
      nc = (int'(load_val) > int'(limit)) ? int'(limit) : int'(load_val);
    end else if (mode == 2'd2 && start) begin
      nc = s; st = 1;
    end else if (en && (mode != 2'd2 || m_state == 1)) begin
      if (c > int'(limit)) nc = t;
      else if (c == t) nc = wrapm ? s : c;
      else nc = dir ? c - 1 : c + 1;
      ntc = (nc == t) && (wrapm || c != t);
      if (mode == 2'd2 && nc == t) st = 2;
    end
    @(posedge clk); #1;
    m_count = nc; m_tc = ntc; m_state = st;
  endtask

  task automatic idle_inputs();
    clr = 0; load = 0; start = 0; en = 0;
  endtask

  task automatic test_reset();
    checks++;
    if ({count, tc, busy, done} !== {W'(0), 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got count=%0d tc=%b busy=%b done=%b, want 0 0 0 0", count, tc, busy, done);
    end
  endtask

  task automatic test_wrap_up();
    mode = 2'b00; dir = 0; limit = 5; en = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (count !== W'((i + 1) % 6) || tc !== ((i + 1) % 6 == 5)) begin
        errors++;
        $display("FAIL wrap_up[%0d]: got count=%0d tc=%b, want count=%0d tc=%b", i, count, tc, (i + 1) % 6, ((i + 1) % 6 == 5));
      end
    end
    idle_inputs();
  endtask

  task automatic test_sat_down();
    int pulses = 0;
    mode = 2'b01; dir = 1; limit = 9; load_val = 3; load = 1;
    tick(); load = 0;
    checks++;
    if (count !== 4'd3 || tc !== 1'b0) begin
      errors++;
      $display("FAIL sat_load: got count=%0d tc=%b, want 3 0", count, tc);
    end
    en = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      pulses += int'(tc);
      checks++;
      if (count !== W'(m_count) || tc !== m_tc) begin
        errors++;
        $display("FAIL sat_down[%0d]: got count=%0d tc=%b, want %0d %b", i, count, tc, m_count, m_tc);
      end
    end
    checks++;
    if (pulses != 1 || count !== 4'd0) begin
      errors++;
      $display("FAIL sat_pulses: got pulses=%0d count=%0d, want 1 0", pulses, count);
    end
    idle_inputs();
  endtask

  task automatic test_oneshot();
    clr = 1; tick(); clr = 0;
    mode = 2'b10; dir = 0; limit = 3; start = 1; en = 1;
    tick(); start = 0;
    checks++;
    if (count !== 4'd0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL os_start: got count=%0d busy=%b done=%b, want 0 1 0", count, busy, done);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (count !== W'(i) || tc !== (i == 3) || busy !== (i != 3) || done !== (i == 3)) begin
        errors++;
        $display("FAIL os_run[%0d]: got count=%0d tc=%b busy=%b done=%b", i, count, tc, busy, done);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (count !== 4'd3 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
        errors++;
        $display("FAIL os_hold[%0d]: got count=%0d tc=%b busy=%b done=%b, want 3 0 0 1", i, count, tc, busy, done);
      end
    end
    start = 1; tick(); start = 0;
    checks++;
    if (count !== 4'd0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL os_restart: got count=%0d busy=%b done=%b, want 0 1 0", count, busy, done);
    end
    // leaving one-shot mode keeps the FSM state visible
    mode = 2'b00; tick();
    checks++;
    if (busy !== 1'b1 || count !== W'(m_count)) begin
      errors++;
      $display("FAIL os_modechg: got busy=%b count=%0d, want 1 %0d", busy, count, m_count);
    end
    idle_inputs();
  endtask

  task automatic test_priority();
    mode = 2'b00; dir = 0; limit = 15;
    load_val = 5; load = 1; tick(); load = 0;
    clr = 1; load = 1; load_val = 9; en = 1;
    tick();
    checks++;
    if (count !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL prio_clr: got count=%0d tc=%b busy=%b, want 0 0 0", count, tc, busy);
    end
    clr = 0; limit = 10; load_val = 12; en = 1;
    tick();
    checks++;
    if (count !== 4'd10 || tc !== 1'b0) begin
      errors++;
      $display("FAIL prio_clamp: got count=%0d tc=%b, want 10 0", count, tc);
    end
    idle_inputs();
  endtask

  task automatic test_limit_shrink();
    mode = 2'b00; dir = 0; limit = 15; load_val = 9; load = 1;
    tick(); load = 0;
    limit = 4; en = 1;
    tick();
    checks++;
    if (count !== 4'd4 || tc !== 1'b1) begin
      errors++;
      $display("FAIL limit_shrink: got count=%0d tc=%b, want 4 1", count, tc);
    end
    // wrap with limit=0 pulses every step
    limit = 0; tick(); tick();
    checks++;
    if (count !== 4'd0 || tc !== 1'b1) begin
      errors++;
      $display("FAIL limit_zero: got count=%0d tc=%b, want 0 1", count, tc);
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    mode = 2'b10; dir = 0; limit = 7; start = 1; tick(); start = 0; en = 1;
    tick(); tick();
    rst_n = 0; #2;
    m_count = 0; m_tc = 0; m_state = 0;
    checks++;
    if ({count, tc, busy, done} !== {W'(0), 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got count=%0d tc=%b busy=%b done=%b, want 0 0 0 0", count, tc, busy, done);
    end
    #1 rst_n = 1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL after_reset: got count=%0d busy=%b done=%b, want 0 0 0", count, busy, done);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clr      = ($urandom_range(0, 31) == 0);
      load     = ($urandom_range(0, 15) == 0);
      start    = ($urandom_range(0, 7) == 0);
      en       = ($urandom_range(0, 3) != 0);
      load_val = W'($urandom);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 23) == 0) limit = W'($urandom);
      tick();
      checks++;
      if (count !== W'(m_count) || tc !== m_tc || busy !== (m_state == 1) || done !== (m_state == 2)) begin
        errors++;
        $display("FAIL random[%0d]: got count=%0d tc=%b busy=%b done=%b, want %0d %b %b %b", i, count, tc, busy, done, m_count, m_tc, m_state == 1, m_state == 2);
      end
    end
    idle_inputs();
  endtask

  initial begin
    #12;
    test_reset();
    rst_n = 1;
    @(posedge clk); #1;
    test_wrap_up();
    test_sat_down();
    test_oneshot();
    test_priority();
    test_limit_shrink();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_counter.md
# prog_counter

Parametrised up/down counter with run-time modulus, three counting modes (wrap, saturate, one-shot), synchronous load/clear and a registered terminal-count pulse. It is the general-purpose counting primitive for the pedal datapath: sample-rate tick dividers, delay-line address generation, and one-shot envelope/timeout timing. It replaces the fixed free-running counter.

## Interface
- WIDTH, 8, counter width in bits; must be at least 2.
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  value loaded when load=1.
- start  in  1  arms a one-shot run; ignored in other modes.
- en  in  1  count enable; one step per enabled edge.
- dir  in  1  count direction: 0 = up, 1 = down.
- mode  in  2  counting mode: 00 = wrap, 01 = saturate, 10 = one-shot, 11 = reserved (behaves as wrap).
- limit  in  WIDTH  modulus; counts span 0..limit inclusive.
- count  out  WIDTH  current count.
- tc  out  1  one-cycle terminal-count pulse.
- busy  out  1  one-shot state is RUN.
- done  out  1  one-shot state is DONE.

## Operation
- **Terminal value (T):** T = limit when dir=0; T = 0 when dir=1.
- **Start value (S):** S = 0 when dir=0; S = limit when dir=1.
- **Priority at each edge:** rst_n, then clr, then load, then start (one-shot mode only), then the step (only when en=1).
- **Reset:** count=0, tc=0, state=IDLE, so busy=0 and done=0.
- **clr:** count<=S, state<=IDLE, tc<=0.
- **load:** count<=min(load_val, limit); tc<=0; state unchanged. Loading a value equal to T does not pulse tc.
- **start (mode=10):** count<=S, state<=RUN, tc<=0. A start while in RUN or DONE restarts the run.
- **Step, wrap mode:** if count==T, count<=S; otherwise count moves one toward T.
- **Step, saturate mode:** if count==T, count holds; otherwise count moves one toward T.
- **Step, one-shot mode:** stepping happens only in state RUN.
  - Count moves one toward T.
  - When the next count equals T, state<=DONE.
  - In IDLE and DONE, en is ignored and count holds.
- **Out-of-range count:** if an enabled step occurs while count>limit (limit was lowered at run time), count<=T and tc pulses.
- **tc rule:** tc<=1 at an enabled step where next count==T and either mode is wrap/reserved or the current count!=T. Otherwise tc<=0.
  - tc therefore pulses once when count reaches T in saturate and one-shot modes.
  - In wrap mode with limit=0, tc pulses on every enabled step.
- **limit=0:** count stays at 0 in all modes; the tc rule above applies unchanged.
- **Run-time changes:** dir, mode and limit may change at any cycle; the new values take effect at the next edge. A dir change mid-run changes T and S immediately.
- **FSM (one-shot mode):**
  - IDLE -> RUN on start.
  - RUN -> DONE on the step that reaches T.
  - DONE -> RUN on start.
  - Any state -> IDLE on clr.
  - Leaving mode 10 does not change the FSM state. busy and done still reflect the FSM state in every mode.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Latency: count, tc, busy and done reflect the inputs sampled at edge N during cycle N+1.
- tc is high in the same cycle that count first shows T. It lasts exactly one cycle unless the next edge is also a qualifying step.
- done rises in the same cycle as the final tc of a one-shot run.
- Asserting rst_n low mid-run forces the reset values immediately, without waiting for a clock edge. Deassertion is synchronised externally.

## Structure
- Package prog_counter_pkg holds:
  - typedef enum logic [1:0] cnt_mode_e: CNT_WRAP, CNT_SAT, CNT_ONESHOT, CNT_RSVD.
  - typedef enum logic [1:0] os_state_e: OS_IDLE, OS_RUN, OS_DONE.
- Single module with no sub-module. The next-count/terminal logic is one always_comb block feeding one always_ff block.

## Test plan
All scenarios use WIDTH=4.
- **Wrap up:** mode=00, dir=0, limit=5, en=1 for 8 cycles -> count goes 0,1,2,3,4,5,0,1,2; tc is high only in the cycle count=5.
- **Saturate down:** mode=01, dir=1, load load_val=3, then en=1 for 6 cycles -> count goes 3,2,1,0,0,0; tc pulses once, in the cycle count first shows 0.
- **One-shot:** mode=10, dir=0, limit=3, start, en=1 -> busy=1, count goes 0,1,2,3; then done=1, busy=0, count holds at 3 with en held high; a second start sets count=0 and busy=1.
- **Priority:** clr, load (load_val=9) and en asserted together -> count=0 and tc=0. load_val=12 with limit=10 -> count=10 and no tc.
- **Limit shrink:** count=9, limit changed to 4, en=1 in wrap mode -> count=4 and tc=1 on the next edge.
- **Async reset:** rst_n pulled low mid-run with no clock edge -> count, tc, busy and done all read 0 immediately; the state is IDLE after release.
